// File: rtl/vram_draw_controller.sv
//============================================================================
// Module      : vram_draw_controller
// Description : Writes a power-on / on-demand clear sweep into a VRAM write
//               port, and stamps a (2*BRUSH_R+1)-square brush around each
//               accepted touch sample. All outputs are registered.
//               Optional feature macro: VRAM_DRAW_DEDUP_EN (drops a touch
//               that repeats the last accepted stroke position).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module vram_draw_controller #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int BRUSH_R        = 1,
  localparam int AW            = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  input  logic          touch_valid,
  input  logic [8:0]    touch_x,
  input  logic [8:0]    touch_y,
  input  logic [15:0]   draw_color,
  input  logic [15:0]   clear_color,
  output logic          vram_wr_ena,
  output logic [AW-1:0] vram_wr_addr,
  output logic [15:0]   vram_wr_data,
  output logic          busy
);

  localparam int                 VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam logic signed [15:0] R_OFF  = 16'(BRUSH_R);

  typedef enum logic [1:0] {
    S_CLEARING = 2'd0,
    S_IDLE     = 2'd1,
    S_BRUSH    = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [AW-1:0]      clr_cnt, clr_cnt_n;
  logic signed [15:0] off_x, off_x_n, off_y, off_y_n;
  logic [8:0]         base_x, base_x_n, base_y, base_y_n;
  logic [15:0]        pen, pen_n;
  logic               wr_ena_n, busy_n;
  logic [AW-1:0]      wr_addr_n;
  logic [15:0]        wr_data_n;

  // Brush stepping and pixel address helpers
  logic               step_last;
  logic signed [15:0] step_dx, step_dy;
  logic [8:0]         calc_x, calc_y;
  logic signed [15:0] calc_dx, calc_dy;
  int                 px, py, lin;
  logic               pix_ok;
  logic [AW-1:0]      pix_addr;
  logic               touch_in_range, dedup_hit, accept;

  // Next brush offset in raster order (dx inner, dy outer)
  always_comb begin
    step_last = (off_x == R_OFF) && (off_y == R_OFF);
    step_dx   = (off_x == R_OFF) ? -R_OFF : off_x + 16'sd1;
    step_dy   = (off_x == R_OFF) ? off_y + 16'sd1 : off_y;
  end

  // Pixel clipping and linear address; signed full-width so edges never wrap
  always_comb begin
    calc_x  = base_x;
    calc_y  = base_y;
    calc_dx = step_dx;
    calc_dy = step_dy;
    if (state == S_IDLE) begin
      calc_x  = touch_x;
      calc_y  = touch_y;
      calc_dx = -R_OFF;
      calc_dy = -R_OFF;
    end
    px       = int'(calc_x) + int'(calc_dx);
    py       = int'(calc_y) + int'(calc_dy);
    pix_ok   = (px >= 0) && (px < DISPLAY_WIDTH) && (py >= 0) && (py < DISPLAY_HEIGHT);
    lin      = pix_ok ? (py * DISPLAY_WIDTH + px) : 0;
    pix_addr = AW'(lin);
  end

  assign touch_in_range = (int'(touch_x) < DISPLAY_WIDTH) && (int'(touch_y) < DISPLAY_HEIGHT);
  assign accept = (state == S_IDLE) && !clear_req && touch_valid && touch_in_range && !dedup_hit;

`ifdef VRAM_DRAW_DEDUP_EN
  logic       dedup_valid;
  logic [8:0] dedup_x, dedup_y;

  assign dedup_hit = dedup_valid && (touch_x == dedup_x) && (touch_y == dedup_y);

  // Remember the last accepted stroke; forgotten on reset and on every clear
  always_ff @(posedge clk) begin
    if (rst || clear_req) begin
      dedup_valid <= 1'b0;
      dedup_x     <= '0;
      dedup_y     <= '0;
    end else if (accept) begin
      dedup_valid <= 1'b1;
      dedup_x     <= touch_x;
      dedup_y     <= touch_y;
    end
  end
`else
  assign dedup_hit = 1'b0;
`endif

  // Next-state and registered-output decode; clear_req overrides every state
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    off_x_n   = off_x;
    off_y_n   = off_y;
    base_x_n  = base_x;
    base_y_n  = base_y;
    pen_n     = pen;
    wr_ena_n  = 1'b0;
    wr_addr_n = vram_wr_addr;
    wr_data_n = vram_wr_data;
    if (clear_req) begin
      state_n   = S_CLEARING;
      clr_cnt_n = '0;
      wr_ena_n  = 1'b1;
      wr_addr_n = '0;
      wr_data_n = clear_color;
    end else begin
      case (state)
        S_CLEARING: begin
          if (clr_cnt == AW'(VRAM_L - 1)) begin
            state_n = S_IDLE;
          end else begin
            clr_cnt_n = clr_cnt + AW'(1);
            wr_ena_n  = 1'b1;
            wr_addr_n = clr_cnt + AW'(1);
            wr_data_n = clear_color;
          end
        end
        S_IDLE: begin
          if (accept) begin
            state_n   = S_BRUSH;
            base_x_n  = touch_x;
            base_y_n  = touch_y;
            pen_n     = draw_color;
            off_x_n   = -R_OFF;
            off_y_n   = -R_OFF;
            wr_ena_n  = pix_ok;
            wr_addr_n = pix_addr;
            wr_data_n = draw_color;
          end
        end
        S_BRUSH: begin
          if (step_last) begin
            state_n = S_IDLE;
          end else begin
            off_x_n   = step_dx;
            off_y_n   = step_dy;
            wr_ena_n  = pix_ok;
            wr_addr_n = pix_addr;
            wr_data_n = pen;
          end
        end
        default: begin
          state_n = S_CLEARING;
        end
      endcase
    end
    busy_n = (state_n != S_IDLE);
  end

  // State, counters and output registers; reset launches the power-on clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLEARING;
      clr_cnt      <= '0;
      off_x        <= '0;
      off_y        <= '0;
      base_x       <= '0;
      base_y       <= '0;
      pen          <= '0;
      vram_wr_ena  <= 1'b1;
      vram_wr_addr <= '0;
      vram_wr_data <= clear_color;
      busy         <= 1'b1;
    end else begin
      state        <= state_n;
      clr_cnt      <= clr_cnt_n;
      off_x        <= off_x_n;
      off_y        <= off_y_n;
      base_x       <= base_x_n;
      base_y       <= base_y_n;
      pen          <= pen_n;
      vram_wr_ena  <= wr_ena_n;
      vram_wr_addr <= wr_addr_n;
      vram_wr_data <= wr_data_n;
      busy         <= busy_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_draw_controller.sv
//============================================================================
// Module      : tb_vram_draw_controller
// Description : Directed bench for vram_draw_controller. A short display
//               (240 x 24) keeps each clear sweep brief while every brush
//               address of interest stays identical to the full-size panel.
//               Honours VRAM_DRAW_DEDUP_EN when defined.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vram_draw_controller;

  localparam int          W   = 240;
  localparam int          H   = 24;
  localparam int          L   = W * H;
  localparam int          AW  = $clog2(L);
  localparam logic [15:0] CLR = 16'h1234;
  localparam logic [15:0] PEN = 16'hF800;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_req = 1'b0;
  logic          touch_valid = 1'b0;
  logic [8:0]    touch_x = '0;
  logic [8:0]    touch_y = '0;
  logic [15:0]   draw_color = PEN;
  logic [15:0]   clear_color = CLR;
  logic          vram_wr_ena;
  logic [AW-1:0] vram_wr_addr;
  logic [15:0]   vram_wr_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  vram_draw_controller #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .BRUSH_R       (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .touch_valid (touch_valid),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .draw_color  (draw_color),
    .clear_color (clear_color),
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge where the first clear write (addr 0) is on the outputs.
  task automatic sweep(input string tag, input bit noise);
    int n   = 0;
    bit bad = 1'b0;
    while (vram_wr_ena === 1'b1 && n < L + 8) begin
      if (vram_wr_addr !== AW'(n) || vram_wr_data !== CLR || busy !== 1'b1) bad = 1'b1;
      touch_valid = noise && (n < L - 2);
      touch_x     = 9'd10;
      touch_y     = 9'd20;
      n++;
      @(negedge clk);
    end
    touch_valid = 1'b0;
    check({tag, " write count"}, n, L);
    check({tag, " sweep content"}, {31'd0, bad}, 32'd0);
    check({tag, " end busy"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " idle wr_ena"}, {31'd0, vram_wr_ena}, 32'd0);
  endtask

  // Expected tables list brush cycles left to right (cycle 0 leftmost).
  task automatic stroke(input string tag, input int x, input int y, input logic [8:0] en,
                        input logic [8:0][31:0] ad, input bit noise);
    touch_x     = 9'(x);
    touch_y     = 9'(y);
    touch_valid = 1'b1;
    @(negedge clk);
    touch_valid = noise;
    touch_x     = 9'd50;
    touch_y     = 9'd5;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s c%0d wr_ena", tag, i), {31'd0, vram_wr_ena}, {31'd0, en[8-i]});
      if (en[8-i]) begin
        check($sformatf("%s c%0d addr", tag, i), 32'(vram_wr_addr), ad[8-i]);
        check($sformatf("%s c%0d data", tag, i), 32'(vram_wr_data), 32'(PEN));
      end
      check($sformatf("%s c%0d busy", tag, i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    touch_valid = 1'b0;
    check({tag, " done busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done wr_ena"}, {31'd0, vram_wr_ena}, 32'd0);
    repeat (2) @(negedge clk);
    check({tag, " after wr_ena"}, {31'd0, vram_wr_ena}, 32'd0);
  endtask

  task automatic no_stroke(input string tag, input int x, input int y);
    touch_x     = 9'(x);
    touch_y     = 9'(y);
    touch_valid = 1'b1;
    @(negedge clk);
    touch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s c%0d wr_ena", tag, i), {31'd0, vram_wr_ena}, 32'd0);
      check($sformatf("%s c%0d busy", tag, i), {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int bad;

    // Reset and automatic power-on clear
    repeat (3) @(negedge clk);
    check("reset wr_ena", {31'd0, vram_wr_ena}, 32'd1);
    check("reset addr", 32'(vram_wr_addr), 32'd0);
    check("reset data", 32'(vram_wr_data), 32'(CLR));
    check("reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    sweep("power-on clear", 1'b0);

    // Out-of-range touches are ignored
    no_stroke("oor x", 240, 0);
    no_stroke("oor y", 0, 24);

    // Interior stroke, with touch noise during the brush
    stroke("stroke 10,20", 10, 20, 9'b111111111,
           {32'd4569, 32'd4570, 32'd4571, 32'd4809, 32'd4810, 32'd4811,
            32'd5049, 32'd5050, 32'd5051}, 1'b1);
    // Top-left corner: only four pixels inside the panel
    stroke("stroke 0,0", 0, 0, 9'b000011011,
           {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd240, 32'd241}, 1'b0);
    // Bottom-right corner: no wrap into the next row or past the end
    stroke("stroke 239,23", 239, 23, 9'b110110000,
           {32'd5518, 32'd5519, 32'd0, 32'd5758, 32'd5759, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b0);

    // Repeated touch at the same spot
    stroke("dedup first", 10, 20, 9'b111111111,
           {32'd4569, 32'd4570, 32'd4571, 32'd4809, 32'd4810, 32'd4811,
            32'd5049, 32'd5050, 32'd5051}, 1'b0);
`ifdef VRAM_DRAW_DEDUP_EN
    no_stroke("dedup repeat", 10, 20);
`else
    stroke("repeat stroke", 10, 20, 9'b111111111,
           {32'd4569, 32'd4570, 32'd4571, 32'd4809, 32'd4810, 32'd4811,
            32'd5049, 32'd5050, 32'd5051}, 1'b0);
`endif

    // clear_req on the 4th brush cycle aborts the stroke
    touch_x = 9'd5;
    touch_y = 9'd5;
    touch_valid = 1'b1;
    @(negedge clk);
    touch_valid = 1'b0;
    check("abort c0 addr", 32'(vram_wr_addr), 32'd964);
    repeat (3) @(negedge clk);
    check("abort c3 addr", 32'(vram_wr_addr), 32'd1204);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("abort clear wr_ena", {31'd0, vram_wr_ena}, 32'd1);
    check("abort clear addr", 32'(vram_wr_addr), 32'd0);
    check("abort clear data", 32'(vram_wr_data), 32'(CLR));
    sweep("abort clear", 1'b0);

    // clear_req and touch together in idle: clear wins
    touch_x = 9'd10;
    touch_y = 9'd20;
    touch_valid = 1'b1;
    clear_req = 1'b1;
    @(negedge clk);
    touch_valid = 1'b0;
    clear_req = 1'b0;
    check("tie addr", 32'(vram_wr_addr), 32'd0);
    check("tie data", 32'(vram_wr_data), 32'(CLR));
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (vram_wr_data !== CLR || vram_wr_ena !== 1'b1) bad = 1;
      @(negedge clk);
    end
    check("tie no pen write", 32'(bad), 32'd0);
    check("tie progress addr", 32'(vram_wr_addr), 32'd30);

    // clear_req during a clear restarts the sweep
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("restart addr", 32'(vram_wr_addr), 32'd0);
    repeat (40) @(negedge clk);
    check("restart progress addr", 32'(vram_wr_addr), 32'd40);

    // rst mid-clear restarts from address 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid addr", 32'(vram_wr_addr), 32'd0);
    check("rst mid busy", {31'd0, busy}, 32'd1);
    sweep("rst clear", 1'b1);

    // Same spot after a clear is accepted again
    stroke("post-clear stroke", 10, 20, 9'b111111111,
           {32'd4569, 32'd4570, 32'd4571, 32'd4809, 32'd4810, 32'd4811,
            32'd5049, 32'd5050, 32'd5051}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vram_draw_controller.md
VRAM_DRAW_CONTROLLER -- requirements
Module: vram_draw_controller

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 240, pixels per row.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 320, rows.
REQ-003 SHALL have parameter BRUSH_R, default 1, brush radius; brush is a (2*BRUSH_R+1)-square.
REQ-004 SHALL have port clk  input  1  system clock; the single clock domain.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port clear_req  input  1  single-cycle request to clear the screen.
REQ-007 SHALL have port touch_valid  input  1  touch sample valid.
REQ-008 SHALL have port touch_x  input  9  touch column.
REQ-009 SHALL have port touch_y  input  9  touch row.
REQ-010 SHALL have port draw_color  input  16  RGB565 pen colour.
REQ-011 SHALL have port clear_color  input  16  RGB565 clear colour.
REQ-012 SHALL have port vram_wr_ena  output  1  VRAM write enable.
REQ-013 SHALL have port vram_wr_addr  output  $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT) (17 at defaults)  VRAM write address.
REQ-014 SHALL have port vram_wr_data  output  16  VRAM write data.
REQ-015 SHALL have port busy  output  1  high in S_CLEARING or S_BRUSH.

Function
REQ-016 SHALL implement states S_CLEARING, S_IDLE and S_BRUSH; all outputs registered.
REQ-017 S_CLEARING SHALL write clear_color to addresses 0..VRAM_L-1 in ascending order, one per cycle, then enter S_IDLE; VRAM_L = DISPLAY_WIDTH*DISPLAY_HEIGHT.
REQ-018 S_IDLE SHALL hold vram_wr_ena=0.
REQ-019 In S_IDLE, touch_valid=1 with touch_x<DISPLAY_WIDTH and touch_y<DISPLAY_HEIGHT SHALL latch x, y and draw_color and enter S_BRUSH; out-of-range touches SHALL be ignored.
REQ-020 S_BRUSH SHALL visit offsets dy=-R..+R (outer) and dx=-R..+R (inner), one per cycle, taking exactly (2R+1)^2 cycles, then return to S_IDLE.
REQ-021 Each S_BRUSH cycle SHALL assert vram_wr_ena=1 with address (y+dy)*DISPLAY_WIDTH+(x+dx) only if 0<=x+dx<DISPLAY_WIDTH and 0<=y+dy<DISPLAY_HEIGHT; otherwise it SHALL assert vram_wr_ena=0 and still consume the cycle.
REQ-022 Address arithmetic SHALL be performed at full width with signed offsets; no truncation or wrap-around into adjacent rows.
REQ-023 The first brush write SHALL appear on the outputs in the cycle after the accepting edge, i.e. 1-cycle latency.
REQ-024 touch_valid during S_BRUSH or S_CLEARING SHALL be ignored and not queued.
REQ-025 clear_req SHALL have priority in every state: from S_IDLE or S_BRUSH it enters S_CLEARING at address 0, and any brush in progress SHALL be aborted; in S_CLEARING it SHALL restart the sweep at address 0.
REQ-026 clear_req and touch_valid in the same S_IDLE cycle SHALL select clearing, and the touch SHALL be dropped.
REQ-027 busy SHALL equal (state != S_IDLE), registered alongside the state.

Reset
REQ-028 rst SHALL force state S_CLEARING, clear counter 0 and brush counters 0, and SHALL invalidate the dedup register.
REQ-029 In the cycle after reset, outputs SHALL be vram_wr_ena=1, vram_wr_addr=0, vram_wr_data=clear_color and busy=1, so that a power-on clear is automatic.
REQ-030 rst asserted mid-brush or mid-clear SHALL restart clearing from address 0.

Configuration
REQ-031 With macro VRAM_DRAW_DEDUP_EN defined, an in-range touch whose (x,y) equals the last accepted stroke SHALL be ignored in S_IDLE; the dedup register SHALL be invalidated by rst and at the entry to every clear.
REQ-032 With VRAM_DRAW_DEDUP_EN undefined, every in-range touch_valid in S_IDLE SHALL start a stroke, and no dedup storage SHALL exist.

Verification
REQ-033 Reset pulse then idle -> exactly 76800 consecutive writes, addr 0..76799 with clear_color, followed by busy=0 and wr_ena=0.
REQ-034 After clear, touch (10,20) for 1 cycle with R=1 -> 9 writes, the first at addr 4569 and the last at addr 5051, all draw_color, then S_IDLE.
REQ-035 Touch (0,0) -> 9 brush cycles, of which only 4 write (addrs 0, 1, 240, 241).
REQ-036 clear_req on the 4th brush cycle -> the next cycle writes addr 0 with clear_color, and no further brush writes occur.
REQ-037 clear_req and touch_valid on the same cycle in S_IDLE -> the clear sweep starts and no draw_color write occurs.
REQ-038 Touch (10,20) twice in separate S_IDLE windows -> with VRAM_DRAW_DEDUP_EN there is a single 9-cycle stroke; without it there are two strokes.
